// File: rtl/stp16cpc26_receiver.sv
// Receiving end of a cascaded STP16CPC26 chain: oversamples the serial lines,
// shifts and latches like the real parts, and flags frames with a wrong bit count.
module stp16cpc26_receiver #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stp16_clk,
   input  logic             stp16_sdi,
   input  logic             stp16_le,
   input  logic             stp16_noe,
   output logic             stp16_sdo,
   output logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] led,
   output logic             o_valid,
   output logic             o_count_error,
   output logic [7:0]       bit_count
);

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
   logic [SYNC_STAGES-1:0] le_sync_q, le_sync_d;
   logic [SYNC_STAGES-1:0] noe_sync_q, noe_sync_d;
   logic                   clk_prev_q, clk_prev_d;
   logic                   le_prev_q, le_prev_d;
   logic [WIDTH-1:0]       shreg_q, shreg_d;
   logic [WIDTH-1:0]       data_q, data_d;
   logic [WIDTH-1:0]       led_q, led_d;
   logic [7:0]             bit_count_q, bit_count_d;
   logic                   valid_q, valid_d;
   logic                   count_error_q, count_error_d;
   logic                   clk_s, sdi_s, le_s, noe_s;
   logic                   clk_rise_s, le_fall_s;
   logic [7:0]             count_inc_s;

   assign clk_s = clk_sync_q[SYNC_STAGES-1];
   assign sdi_s = sdi_sync_q[SYNC_STAGES-1];
   assign le_s  = le_sync_q[SYNC_STAGES-1];
   assign noe_s = noe_sync_q[SYNC_STAGES-1];

   // Next-state: synchronizers, edge detect, shift, latch, count check, LED gating
   always_comb begin
      clk_sync_d    = {clk_sync_q[SYNC_STAGES-2:0], stp16_clk};
      sdi_sync_d    = {sdi_sync_q[SYNC_STAGES-2:0], stp16_sdi};
      le_sync_d     = {le_sync_q[SYNC_STAGES-2:0], stp16_le};
      noe_sync_d    = {noe_sync_q[SYNC_STAGES-2:0], stp16_noe};
      clk_prev_d    = clk_s;
      le_prev_d     = le_s;
      clk_rise_s    = clk_s & ~clk_prev_q;
      le_fall_s     = ~le_s & le_prev_q;
      shreg_d       = shreg_q;
      count_inc_s   = bit_count_q;
      data_d        = data_q;
      bit_count_d   = bit_count_q;
      valid_d       = 1'b0;
      count_error_d = count_error_q;

      if (clk_rise_s) begin
         shreg_d = {shreg_q[WIDTH-2:0], sdi_s};
         if (bit_count_q != 8'd255) begin
            count_inc_s = bit_count_q + 8'd1;
         end else begin
            count_inc_s = bit_count_q;
         end
      end else begin
         shreg_d     = shreg_q;
         count_inc_s = bit_count_q;
      end

      // A shift coinciding with the LE fall is counted and captured by the latch
      if (le_fall_s) begin
         data_d        = shreg_d;
         valid_d       = 1'b1;
         count_error_d = (32'(count_inc_s) != 32'(WIDTH));
         bit_count_d   = 8'd0;
      end else if (le_s) begin
         data_d      = shreg_d;
         bit_count_d = count_inc_s;
      end else begin
         data_d      = data_q;
         bit_count_d = count_inc_s;
      end

      if (noe_s) begin
         led_d = {WIDTH{1'b0}};
      end else begin
         led_d = data_d;
      end
   end

   // State registers with synchronous reset; NOE synchronizer resets to disabled
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync_q    <= {SYNC_STAGES{1'b0}};
         sdi_sync_q    <= {SYNC_STAGES{1'b0}};
         le_sync_q     <= {SYNC_STAGES{1'b0}};
         noe_sync_q    <= {SYNC_STAGES{1'b1}};
         clk_prev_q    <= 1'b0;
         le_prev_q     <= 1'b0;
         shreg_q       <= {WIDTH{1'b0}};
         data_q        <= {WIDTH{1'b0}};
         led_q         <= {WIDTH{1'b0}};
         bit_count_q   <= 8'd0;
         valid_q       <= 1'b0;
         count_error_q <= 1'b0;
      end else begin
         clk_sync_q    <= clk_sync_d;
         sdi_sync_q    <= sdi_sync_d;
         le_sync_q     <= le_sync_d;
         noe_sync_q    <= noe_sync_d;
         clk_prev_q    <= clk_prev_d;
         le_prev_q     <= le_prev_d;
         shreg_q       <= shreg_d;
         data_q        <= data_d;
         led_q         <= led_d;
         bit_count_q   <= bit_count_d;
         valid_q       <= valid_d;
         count_error_q <= count_error_d;
      end
   end

   assign stp16_sdo     = shreg_q[WIDTH-1];
   assign data          = data_q;
   assign led           = led_q;
   assign o_valid       = valid_q;
   assign o_count_error = count_error_q;
   assign bit_count     = bit_count_q;

endmodule

// File: tb/tb_stp16cpc26_receiver.sv
// Randomized self-checking bench for stp16cpc26_receiver against a bit-history model.
module tb_stp16cpc26_receiver;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stp16_clk = 1'b0;
   logic        stp16_sdi = 1'b0;
   logic        stp16_le = 1'b0;
   logic        stp16_noe = 1'b0;
   logic        stp16_sdo;
   logic [31:0] data;
   logic [31:0] led;
   logic        o_valid;
   logic        o_count_error;
   logic [7:0]  bit_count;

   int          n_checks = 0;
   int          n_errors = 0;
   int          vcnt = 0;
   logic [31:0] got_data;
   logic        got_err;

   // Model: every bit shifted since reset, and bits shifted since the last latch
   bit          hist[$];
   int          m_count = 0;
   logic [31:0] m_latched = 32'd0;

   stp16cpc26_receiver #(.WIDTH(32), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset),
      .stp16_clk(stp16_clk), .stp16_sdi(stp16_sdi),
      .stp16_le(stp16_le), .stp16_noe(stp16_noe),
      .stp16_sdo(stp16_sdo), .data(data), .led(led),
      .o_valid(o_valid), .o_count_error(o_count_error), .bit_count(bit_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_valid) begin
         vcnt     = vcnt + 1;
         got_data = data;
         got_err  = o_count_error;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (obs !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_data();
      logic [31:0] v = 32'd0;
      for (int i = 0; i < 32; i++)
         if (hist.size() > i) v[i] = hist[hist.size()-1-i];
      return v;
   endfunction

   function automatic logic model_sdo();
      if (hist.size() >= 32) return hist[hist.size()-32];
      return 1'b0;
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic shift_bit(input bit b);
      stp16_sdi = b;
      cycles(2);
      stp16_clk = 1'b1;
      cycles(2);
      stp16_clk = 1'b0;
      cycles(2);
      hist.push_back(b);
      m_count = m_count + 1;
      check_val("sdo", 32'(stp16_sdo), 32'(model_sdo()));
      check_val("bit_count", 32'(bit_count), (m_count > 255) ? 32'd255 : 32'(m_count));
   endtask

   task automatic shift_word(input logic [31:0] w, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) shift_bit(w[i]);
   endtask

   task automatic do_latch(input bit with_shift, input bit b);
      int v0 = vcnt;
      if (with_shift) begin
         stp16_sdi = b;
         stp16_le  = 1'b1;
         cycles(2);
         stp16_clk = 1'b1;
         stp16_le  = 1'b0;
         cycles(2);
         stp16_clk = 1'b0;
         hist.push_back(b);
         m_count = m_count + 1;
      end else begin
         stp16_le = 1'b1;
         cycles(2);
         stp16_le = 1'b0;
      end
      cycles(6);
      m_latched = model_data();
      check_val("valid_pulses", 32'(vcnt - v0), 32'd1);
      check_val("valid_data", got_data, m_latched);
      check_val("valid_err", 32'(got_err), 32'(m_count != 32));
      check_val("data", data, m_latched);
      check_val("count_error", 32'(o_count_error), 32'(m_count != 32));
      check_val("led", led, stp16_noe ? 32'd0 : m_latched);
      check_val("bit_count_clr", 32'(bit_count), 32'd0);
      m_count = 0;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      stp16_clk = 1'b1;
      stp16_le  = 1'b1;
      stp16_sdi = 1'b1;
      cycles(1);
      stp16_clk = 1'b0;
      stp16_le  = 1'b0;
      stp16_sdi = 1'b0;
      cycles(1);
      reset = 1'b0;
      hist.delete();
      m_count   = 0;
      m_latched = 32'd0;
   endtask

   initial begin
      int v0;
      int len;
      logic [31:0] w;

      // Reset with inputs toggling
      cycles(1);
      v0 = vcnt;
      do_reset();
      cycles(4);
      check_val("rst_data", data, 32'd0);
      check_val("rst_led", led, 32'd0);
      check_val("rst_bit_count", 32'(bit_count), 32'd0);
      check_val("rst_err", 32'(o_count_error), 32'd0);
      check_val("rst_sdo", 32'(stp16_sdo), 32'd0);
      check_val("rst_no_valid", 32'(vcnt - v0), 32'd0);

      // Single frame
      shift_word(32'h12345678, 32);
      do_latch(1'b0, 1'b0);
      check_val("single_data", data, 32'h12345678);

      // Output enable gating
      stp16_noe = 1'b1;
      cycles(4);
      check_val("noe_led_off", led, 32'd0);
      check_val("noe_data_kept", data, 32'h12345678);
      stp16_noe = 1'b0;
      cycles(4);
      check_val("noe_led_on", led, 32'h12345678);
      check_val("err_held", 32'(o_count_error), 32'd0);

      // Short and long frames
      shift_word($urandom, 31);
      do_latch(1'b0, 1'b0);
      shift_word(32'hF, 4);
      shift_word(32'hA5A5A5A5, 32);
      do_latch(1'b0, 1'b0);
      check_val("long_data", data, 32'hA5A5A5A5);

      // Last shift coincides with the LE fall
      w = $urandom;
      shift_word(w >> 1, 31);
      do_latch(1'b1, w[0]);
      check_val("coincident_data", data, w);

      // Back-to-back frames
      shift_word(32'h12345678, 32);
      do_latch(1'b0, 1'b0);
      shift_word(32'h55555555, 32);
      do_latch(1'b0, 1'b0);

      // Randomized frames, lengths and output enable
      for (int f = 0; f < 8; f++) begin
         len = ($urandom_range(0, 2) == 0) ? $urandom_range(28, 36) : 32;
         stp16_noe = 1'($urandom_range(0, 1));
         for (int i = 0; i < len; i++) shift_bit(1'($urandom));
         do_latch(1'($urandom_range(0, 1)), 1'($urandom));
      end
      stp16_noe = 1'b0;

      // Bit counter saturation
      for (int i = 0; i < 260; i++) shift_bit(1'($urandom));
      do_latch(1'b0, 1'b0);

      // Reset mid-frame discards the partial frame
      shift_word(32'hDEAD, 16);
      do_reset();
      cycles(4);
      check_val("midrst_bit_count", 32'(bit_count), 32'd0);
      check_val("midrst_data", data, 32'd0);
      shift_word(32'h0000FFFF, 32);
      do_latch(1'b0, 1'b0);
      check_val("midrst_frame", data, 32'h0000FFFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
